ntt_layer_ctrl: RTL and testbench
=================================

// Module: ntt_layer_ctrl
// PURPOSE
//  Parametrised layer-sequencing controller for the NTT/INTT datapath.
//  Runs load -> N-layer butterfly compute -> unload on ping-pong RAMs; selects forward or inverse layer order.
//  Generates pipelined rd/wr strobes, bank selects, layer and butterfly indices.
//  Sits between the top-level handshake logic and the butterfly/RAM datapath.
// PARAMETERS
//  DEPTH       8          log2(N) coefficients; butterflies per layer BF = 2^(DEPTH-1)
//  NUM_LAYERS  DEPTH-1    compute layers per transform (7 for Kyber)
//  PIPE_LAT    5          cycles from butterfly read to its write-back; 1 <= PIPE_LAT < BF
//  LW          3          layer index width, 2^LW >= NUM_LAYERS
// PORTS
//  clk          in   1        clock, rising edge
//  reset_n      in   1        asynchronous reset, active low
//  set          in   1        global enable; 0 freezes all state and outputs
//  mode         in   1        0 = forward NTT, 1 = inverse NTT; sampled on WAIT_CAL->FILL
//  readin       in   1        request to start loading
//  full_in      in   1        input RAM load complete
//  cal_en       in   1        permission to start compute
//  full_out     in   1        unload complete
//  abort        in   1        synchronous return to IDLE
//  rd_en        out  1        butterfly read strobe
//  wr_en        out  1        butterfly write strobe
//  rd_bank      out  1        bank read this layer (0 = ram1, 1 = ram2)
//  ram1_we      out  1        ram1 write enable (load or compute write)
//  ram2_we      out  1        ram2 write enable
//  layer_idx    out  LW       twiddle layer index of current read
//  bf_idx       out  DEPTH-1  butterfly index of current read
//  result_bank  out  1        bank holding final result (NUM_LAYERS % 2)
//  readin_ok    out  1        ready to accept load
//  busy         out  1        in FILL/STEADY/DRAIN/GAP
//  done         out  1        result valid, waiting for unload
//  cycle_cnt    out  16       only with NTT_LAYER_CTRL_PERF_EN
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except readin_ok=1; counters 0.
//  States: IDLE, LOAD, WAIT_CAL, FILL, STEADY, DRAIN, GAP, DONE.
//   IDLE: readin -> LOAD.  LOAD: ram1_we=1; full_in -> WAIT_CAL.
//   WAIT_CAL: readin_ok=0; cal_en -> FILL; latch mode; k=0.
//   FILL (PIPE_LAT cyc): rd_en=1, wr_en=0.  STEADY (BF-PIPE_LAT cyc): rd_en=wr_en=1.
//   DRAIN (PIPE_LAT cyc): rd_en=0, wr_en=1.  GAP (1 cyc): no strobes; k++.
//   GAP: k==NUM_LAYERS -> DONE, else -> FILL.  DONE: done=1; full_out -> IDLE.
//  Layer k: length BF+PIPE_LAT+1 cycles; transform = NUM_LAYERS*(BF+PIPE_LAT+1).
//  bf_idx counts 0..BF-1 over FILL+STEADY, wraps to 0 entering DRAIN.
//  layer_idx = k (forward) or NUM_LAYERS-1-k (inverse).
//  rd_bank = k[0]; compute writes go to bank ~k[0]: ram2_we=wr_en&~k[0], ram1_we=wr_en&k[0].
//  All outputs registered; strobes change on the state-entry edge.
//  abort=1 (any state, set=1): next cycle IDLE, strobes 0, counters cleared; abort beats readin/cal_en.
//  full_in/cal_en/full_out ignored outside their own state; mode changes mid-transform ignored.
//  set=0 mid-layer: strobes held, counters frozen; resume exactly where paused.
//  reset_n low mid-transform: immediate return to reset values, no write completes.
// CONFIGURATION
//  NTT_LAYER_CTRL_PERF_EN defined: cycle_cnt clears on WAIT_CAL->FILL, +1 per enabled cycle until DONE, holds in DONE, saturates 16'hFFFF.
//  Undefined: cycle_cnt port and counter absent; all else identical.
// STRUCTURE
//  Package ntt_pkg: state encoding (one-hot localparams), BF/layer-length helper functions, bank constants.
//  Sub-module ntt_layer_cnt: phase counter + bf_idx with terminal-count flags, reused per phase.
// TESTING (DEPTH=4, NUM_LAYERS=3, PIPE_LAT=3: BF=8, layer=12 cyc)
//  readin, full_in 4 cyc later -> ram1_we high 4 cyc; WAIT_CAL; readin_ok=0.
//  cal_en, mode=0 -> rd_en 8 cyc, wr_en 8 cyc offset 3; layer_idx 0,1,2; done 36 cyc after FILL entry.
//  mode=1 -> layer_idx 2,1,0; rd_bank 0,1,0; write banks 1,0,1; result_bank=1.
//  abort at STEADY of layer 1 -> next cycle IDLE, rd_en=wr_en=0, readin_ok=1.
//  set=0 for 5 cyc in layer 0 STEADY -> bf_idx frozen; total still 36 enabled cycles.
//  reset_n pulse during DRAIN -> outputs at reset values same cycle; PERF_EN build: cycle_cnt=36 in DONE.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and helpers for the NTT layer controller
//
// Purpose : one-hot state encoding, bank constants and butterfly/layer-length
//           helpers used by ntt_layer_ctrl and ntt_layer_cnt.
// Ports   : none (package).

package ntt_pkg;

    // One-hot controller states
    localparam logic [7:0] ST_IDLE     = 8'b0000_0001;
    localparam logic [7:0] ST_LOAD     = 8'b0000_0010;
    localparam logic [7:0] ST_WAIT_CAL = 8'b0000_0100;
    localparam logic [7:0] ST_FILL     = 8'b0000_1000;
    localparam logic [7:0] ST_STEADY   = 8'b0001_0000;
    localparam logic [7:0] ST_DRAIN    = 8'b0010_0000;
    localparam logic [7:0] ST_GAP      = 8'b0100_0000;
    localparam logic [7:0] ST_DONE     = 8'b1000_0000;

    // Ping-pong bank identifiers
    localparam logic BANK_RAM1 = 1'b0;
    localparam logic BANK_RAM2 = 1'b1;

    // Butterflies per layer for 2^depth coefficients
    function automatic int bf_count(input int depth);
        return 1 << (depth - 1);
    endfunction

    // Cycles per compute layer: fill + steady + drain + one gap cycle
    function automatic int layer_len(input int depth, input int pipe_lat);
        return bf_count(depth) + pipe_lat + 1;
    endfunction

endpackage

// File: rtl/ntt_layer_cnt.sv
// rtl/ntt_layer_cnt.sv - per-phase cycle counter and butterfly index counter
//
// Purpose : counts cycles inside the current phase (length supplied by the
//           controller, so one counter serves FILL/STEADY/DRAIN/GAP) and keeps
//           the butterfly read index.
// Ports   : clk, reset_n      clock / async active-low reset
//           i_en              global enable; 0 freezes both counters
//           i_phase_clr       hold the phase counter at 0
//           i_phase_len [CW]  length of the current phase in cycles (>= 1)
//           i_bf_clr          hold the butterfly index at 0
//           i_bf_inc          a butterfly read happens this cycle
//           o_phase_last      current cycle is the last of the phase
//           o_bf_idx [CW]     butterfly index of the current read

module ntt_layer_cnt #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_en,
    input  logic          i_phase_clr,
    input  logic [CW-1:0] i_phase_len,
    input  logic          i_bf_clr,
    input  logic          i_bf_inc,
    output logic          o_phase_last,
    output logic [CW-1:0] o_bf_idx
);

    logic [CW-1:0] r_phase;
    logic [CW-1:0] r_bf;
    logic          w_phase_last;

    assign w_phase_last = (r_phase == (i_phase_len - CW'(1)));

    // Phase counter self-wraps at its terminal count so the next phase
    // starts at 0 without an explicit clear from the controller.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (i_en) begin
            if (i_phase_clr || w_phase_last) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + CW'(1);
            end
        end
    end

    // The index is exactly log2(BF) bits wide, so after BF reads it wraps
    // to 0 on its own, which is the value shown through DRAIN and GAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bf <= '0;
        end else if (i_en) begin
            if (i_bf_clr) begin
                r_bf <= '0;
            end else if (i_bf_inc) begin
                r_bf <= r_bf + CW'(1);
            end
        end
    end

    assign o_phase_last = w_phase_last;
    assign o_bf_idx     = r_bf;

endmodule

// File: rtl/ntt_layer_ctrl.sv
// rtl/ntt_layer_ctrl.sv - load / layered butterfly compute / unload sequencer
//
// Purpose : sequences one NTT (mode=0) or INTT (mode=1) over ping-pong RAMs:
//           LOAD into ram1, NUM_LAYERS layers of FILL/STEADY/DRAIN/GAP, then
//           DONE until the result is unloaded. All outputs are registered.
// Option  : define NTT_LAYER_CTRL_PERF_EN to add the cycle_cnt port/counter.
// Ports   : clk, reset_n            clock / async active-low reset
//           set                     global enable (0 freezes everything)
//           mode                    0 forward, 1 inverse (latched at compute start)
//           readin, full_in         load request / load complete
//           cal_en, full_out        compute permission / unload complete
//           abort                   synchronous return to IDLE
//           rd_en, wr_en            butterfly read / write-back strobes
//           rd_bank                 bank read in this layer (0 ram1, 1 ram2)
//           ram1_we, ram2_we        RAM write enables (load and compute)
//           layer_idx [LW]          twiddle layer of the current read
//           bf_idx [DEPTH-1]        butterfly index of the current read
//           result_bank             bank holding the result (valid with done)
//           readin_ok, busy, done   status
//           cycle_cnt [16]          compute cycle count (option only)

module ntt_layer_ctrl
    import ntt_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int NUM_LAYERS = DEPTH - 1,
    parameter int PIPE_LAT   = 5,
    parameter int LW         = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set,
    input  logic             mode,
    input  logic             readin,
    input  logic             full_in,
    input  logic             cal_en,
    input  logic             full_out,
    input  logic             abort,
    output logic             rd_en,
    output logic             wr_en,
    output logic             rd_bank,
    output logic             ram1_we,
    output logic             ram2_we,
    output logic [LW-1:0]    layer_idx,
    output logic [DEPTH-2:0] bf_idx,
    output logic             result_bank,
    output logic             readin_ok,
    output logic             busy,
    output logic             done
`ifdef NTT_LAYER_CTRL_PERF_EN
    ,
    output logic [15:0]      cycle_cnt
`endif
);

    localparam int BF = bf_count(DEPTH);
    localparam int CW = DEPTH - 1;
    localparam int KW = LW + 1;   // k must reach NUM_LAYERS, which may equal 2^LW

    localparam logic [CW-1:0] LEN_PIPE    = CW'(PIPE_LAT);
    localparam logic [CW-1:0] LEN_STEADY  = CW'(BF - PIPE_LAT);
    localparam logic [CW-1:0] LEN_GAP     = CW'(1);
    localparam logic [KW-1:0] K_LAST      = KW'(NUM_LAYERS);
    localparam logic [LW-1:0] L_TOP       = LW'(NUM_LAYERS - 1);
    localparam logic          RESULT_BANK = ((NUM_LAYERS % 2) == 1) ? BANK_RAM2 : BANK_RAM1;

    logic [7:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_mode;
    logic          r_rd_en;
    logic          r_wr_en;
    logic          r_rd_bank;
    logic          r_ram1_we;
    logic          r_ram2_we;
    logic [LW-1:0] r_layer_idx;
    logic          r_result_bank;
    logic          r_readin_ok;
    logic          r_busy;
    logic          r_done;

    logic [7:0]    w_state_nxt;
    logic [KW-1:0] w_k_nxt;
    logic [KW-1:0] w_k_inc;
    logic          w_mode_nxt;
    logic [CW-1:0] w_phase_len;
    logic          w_phase_last;
    logic [CW-1:0] w_bf_idx;
    logic          w_in_compute;
    logic          w_in_read;
    logic          w_cnt_clr;
    logic [LW-1:0] w_layer_nxt;
    logic          w_bank_nxt;
    logic          w_rd_nxt;
    logic          w_wr_nxt;

    assign w_in_compute = |(r_state & (ST_FILL | ST_STEADY | ST_DRAIN | ST_GAP));
    assign w_in_read    = |(r_state & (ST_FILL | ST_STEADY));
    assign w_cnt_clr    = abort | ~w_in_compute;
    assign w_k_inc      = r_k + KW'(1);

    always_comb begin
        w_phase_len = LEN_GAP;
        if ((r_state == ST_FILL) || (r_state == ST_DRAIN)) begin
            w_phase_len = LEN_PIPE;
        end else if (r_state == ST_STEADY) begin
            w_phase_len = LEN_STEADY;
        end
    end

    ntt_layer_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_en         (set),
        .i_phase_clr  (w_cnt_clr),
        .i_phase_len  (w_phase_len),
        .i_bf_clr     (w_cnt_clr),
        .i_bf_inc     (w_in_read),
        .o_phase_last (w_phase_last),
        .o_bf_idx     (w_bf_idx)
    );

    // Next-state logic; abort takes priority over every other request.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_mode_nxt  = r_mode;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (readin) w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    if (full_in) w_state_nxt = ST_WAIT_CAL;
                end
                ST_WAIT_CAL: begin
                    if (cal_en) begin
                        w_state_nxt = ST_FILL;
                        w_mode_nxt  = mode;
                        w_k_nxt     = '0;
                    end
                end
                ST_FILL: begin
                    if (w_phase_last) w_state_nxt = ST_STEADY;
                end
                ST_STEADY: begin
                    if (w_phase_last) w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_phase_last) w_state_nxt = ST_GAP;
                end
                ST_GAP: begin
                    w_k_nxt     = w_k_inc;
                    w_state_nxt = (w_k_inc == K_LAST) ? ST_DONE : ST_FILL;
                end
                ST_DONE: begin
                    if (full_out) begin
                        w_state_nxt = ST_IDLE;
                        w_k_nxt     = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_k_nxt     = '0;
                end
            endcase
        end
    end

    // Layer index and read bank are loaded on FILL entry and held for the
    // rest of the layer (and through DONE), cleared on return to IDLE.
    always_comb begin
        w_layer_nxt = r_layer_idx;
        w_bank_nxt  = r_rd_bank;
        if (w_state_nxt == ST_FILL) begin
            w_layer_nxt = w_mode_nxt ? (L_TOP - w_k_nxt[LW-1:0]) : w_k_nxt[LW-1:0];
            w_bank_nxt  = w_k_nxt[0];
        end else if (w_state_nxt == ST_IDLE) begin
            w_layer_nxt = '0;
            w_bank_nxt  = 1'b0;
        end
    end

    assign w_rd_nxt = (w_state_nxt == ST_FILL)   || (w_state_nxt == ST_STEADY);
    assign w_wr_nxt = (w_state_nxt == ST_STEADY) || (w_state_nxt == ST_DRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_mode        <= 1'b0;
            r_rd_en       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_ram1_we     <= 1'b0;
            r_ram2_we     <= 1'b0;
            r_layer_idx   <= '0;
            r_result_bank <= 1'b0;
            r_readin_ok   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (set) begin
            r_state       <= w_state_nxt;
            r_k           <= w_k_nxt;
            r_mode        <= w_mode_nxt;
            r_rd_en       <= w_rd_nxt;
            r_wr_en       <= w_wr_nxt;
            r_rd_bank     <= w_bank_nxt;
            r_layer_idx   <= w_layer_nxt;
            // Compute write-back lands in the bank not being read this layer.
            r_ram1_we     <= (w_state_nxt == ST_LOAD) | (w_wr_nxt & (w_bank_nxt == BANK_RAM2));
            r_ram2_we     <= w_wr_nxt & (w_bank_nxt == BANK_RAM1);
            r_result_bank <= (w_state_nxt == ST_DONE) ? RESULT_BANK : 1'b0;
            r_readin_ok   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
            r_busy        <= |(w_state_nxt & (ST_FILL | ST_STEADY | ST_DRAIN | ST_GAP));
            r_done        <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef NTT_LAYER_CTRL_PERF_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt <= '0;
        end else if (set) begin
            if (abort) begin
                r_cycle_cnt <= '0;
            end else if ((r_state == ST_WAIT_CAL) && cal_en) begin
                r_cycle_cnt <= '0;
            end else if (w_in_compute && (r_cycle_cnt != 16'hFFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

    assign rd_en       = r_rd_en;
    assign wr_en       = r_wr_en;
    assign rd_bank     = r_rd_bank;
    assign ram1_we     = r_ram1_we;
    assign ram2_we     = r_ram2_we;
    assign layer_idx   = r_layer_idx;
    assign bf_idx      = w_bf_idx;
    assign result_bank = r_result_bank;
    assign readin_ok   = r_readin_ok;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// tb/tb_ntt_layer_ctrl.sv - directed table-driven bench for ntt_layer_ctrl

module tb_ntt_layer_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       set = 1'b1;
    logic       mode = 1'b0;
    logic       readin = 1'b0;
    logic       full_in = 1'b0;
    logic       cal_en = 1'b0;
    logic       full_out = 1'b0;
    logic       abort = 1'b0;
    logic       rd_en, wr_en, rd_bank, ram1_we, ram2_we;
    logic [1:0] layer_idx;
    logic [2:0] bf_idx;
    logic       result_bank, readin_ok, busy, done;
`ifdef NTT_LAYER_CTRL_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ntt_layer_ctrl #(
        .DEPTH      (4),
        .NUM_LAYERS (3),
        .PIPE_LAT   (3),
        .LW         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .set         (set),
        .mode        (mode),
        .readin      (readin),
        .full_in     (full_in),
        .cal_en      (cal_en),
        .full_out    (full_out),
        .abort       (abort),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .rd_bank     (rd_bank),
        .ram1_we     (ram1_we),
        .ram2_we     (ram2_we),
        .layer_idx   (layer_idx),
        .bf_idx      (bf_idx),
        .result_bank (result_bank),
        .readin_ok   (readin_ok),
        .busy        (busy),
        .done        (done)
`ifdef NTT_LAYER_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    typedef struct {
        int mode;
        int cyc;
        int rd;
        int wr;
        int bf;
        int lay;
        int bank;
        int we1;
        int we2;
        int bsy;
        int dn;
    } vec_t;

    typedef struct {
        int rd;
        int wr;
        int bf;
        int lay;
        int bank;
        int we1;
        int we2;
        int bsy;
        int dn;
    } snap_t;

    vec_t  vecs[$];
    snap_t snap[40];

    function automatic vec_t mk(int m, int c, int rd, int wr, int bf, int lay,
                                int bank, int we1, int we2, int bsy, int dn);
        vec_t v;
        v.mode = m; v.cyc = c; v.rd = rd; v.wr = wr; v.bf = bf; v.lay = lay;
        v.bank = bank; v.we1 = we1; v.we2 = we2; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // readin, then full_in four cycles later; ends in WAIT_CAL
    task automatic do_load(input string tag);
        int n;
        n = 0;
        readin = 1'b1;
        tick();
        readin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n += int'(ram1_we);
            if (i == 3) full_in = 1'b1;
            tick();
        end
        full_in = 1'b0;
        chk({tag, " load ram1_we cycles"}, n, 4);
        chk({tag, " wait_cal ram1_we"}, int'(ram1_we), 0);
        chk({tag, " wait_cal readin_ok"}, int'(readin_ok), 0);
    endtask

    task automatic start(input logic m);
        mode   = m;
        cal_en = 1'b1;
        tick();
        cal_en = 1'b0;
        mode   = ~m;   // must have no effect once the transform is running
    endtask

    task automatic unload(input string tag);
        full_out = 1'b1;
        tick();
        full_out = 1'b0;
        chk({tag, " idle readin_ok"}, int'(readin_ok), 1);
        chk({tag, " idle done"}, int'(done), 0);
        chk({tag, " idle result_bank"}, int'(result_bank), 0);
    endtask

    initial begin
        int n_rd, n_wr, first_wr, n;

        // Transform waveform expectations: DEPTH=4, PIPE_LAT=3, 12-cycle layers.
        //           mode cyc rd wr bf lay bank we1 we2 bsy dn
        vecs.push_back(mk(0,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0,  2, 1, 0, 2, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0,  3, 1, 1, 3, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0,  7, 1, 1, 7, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0,  8, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 12, 1, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 15, 1, 1, 3, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 20, 0, 1, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 24, 1, 0, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 30, 1, 1, 6, 2, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 35, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 36, 0, 0, 0, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1,  0, 1, 0, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1,  3, 1, 1, 3, 2, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 12, 1, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 16, 1, 1, 4, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 24, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 27, 1, 1, 3, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 36, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset ram1_we", int'(ram1_we), 0);
        chk("reset readin_ok", int'(readin_ok), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        reset_n = 1'b1;
        tick();

        // cal_en outside WAIT_CAL is ignored
        cal_en = 1'b1;
        tick();
        cal_en = 1'b0;
        chk("idle cal_en busy", int'(busy), 0);
        chk("idle cal_en readin_ok", int'(readin_ok), 1);

        // Full transforms in both directions, captured then checked from the table
        for (int m = 0; m < 2; m++) begin
            do_load($sformatf("m%0d", m));
            start(m[0]);
            for (int c = 0; c < 40; c++) begin
                snap[c].rd = int'(rd_en);   snap[c].wr = int'(wr_en);
                snap[c].bf = int'(bf_idx);  snap[c].lay = int'(layer_idx);
                snap[c].bank = int'(rd_bank);
                snap[c].we1 = int'(ram1_we); snap[c].we2 = int'(ram2_we);
                snap[c].bsy = int'(busy);   snap[c].dn = int'(done);
                tick();
            end
            foreach (vecs[i]) begin
                if (vecs[i].mode == m) begin
                    chk($sformatf("m%0d c%0d rd_en", m, vecs[i].cyc), snap[vecs[i].cyc].rd, vecs[i].rd);
                    chk($sformatf("m%0d c%0d wr_en", m, vecs[i].cyc), snap[vecs[i].cyc].wr, vecs[i].wr);
                    chk($sformatf("m%0d c%0d bf_idx", m, vecs[i].cyc), snap[vecs[i].cyc].bf, vecs[i].bf);
                    chk($sformatf("m%0d c%0d layer_idx", m, vecs[i].cyc), snap[vecs[i].cyc].lay, vecs[i].lay);
                    chk($sformatf("m%0d c%0d rd_bank", m, vecs[i].cyc), snap[vecs[i].cyc].bank, vecs[i].bank);
                    chk($sformatf("m%0d c%0d ram1_we", m, vecs[i].cyc), snap[vecs[i].cyc].we1, vecs[i].we1);
                    chk($sformatf("m%0d c%0d ram2_we", m, vecs[i].cyc), snap[vecs[i].cyc].we2, vecs[i].we2);
                    chk($sformatf("m%0d c%0d busy", m, vecs[i].cyc), snap[vecs[i].cyc].bsy, vecs[i].bsy);
                    chk($sformatf("m%0d c%0d done", m, vecs[i].cyc), snap[vecs[i].cyc].dn, vecs[i].dn);
                end
            end
            n_rd = 0; n_wr = 0; first_wr = -1;
            for (int c = 0; c < 40; c++) begin
                n_rd += snap[c].rd;
                n_wr += snap[c].wr;
                if (first_wr < 0 && snap[c].wr == 1) first_wr = c;
            end
            chk($sformatf("m%0d rd_en total", m), n_rd, 24);
            chk($sformatf("m%0d wr_en total", m), n_wr, 24);
            chk($sformatf("m%0d first wr_en cycle", m), first_wr, 3);
            chk($sformatf("m%0d done before 36", m), snap[35].dn, 0);
            chk($sformatf("m%0d result_bank", m), int'(result_bank), 1);
            chk($sformatf("m%0d done held", m), int'(done), 1);
`ifdef NTT_LAYER_CTRL_PERF_EN
            chk($sformatf("m%0d cycle_cnt", m), int'(cycle_cnt), 36);
`endif
            unload($sformatf("m%0d", m));
        end

        // Abort during layer-1 STEADY
        do_load("abort");
        start(1'b0);
        repeat (16) tick();
        chk("abort pre rd_en", int'(rd_en), 1);
        chk("abort pre layer_idx", int'(layer_idx), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort rd_en", int'(rd_en), 0);
        chk("abort wr_en", int'(wr_en), 0);
        chk("abort readin_ok", int'(readin_ok), 1);
        chk("abort busy", int'(busy), 0);
        chk("abort bf_idx", int'(bf_idx), 0);

        // Abort wins over a simultaneous readin
        abort  = 1'b1;
        readin = 1'b1;
        tick();
        abort  = 1'b0;
        readin = 1'b0;
        chk("abort vs readin ram1_we", int'(ram1_we), 0);
        chk("abort vs readin readin_ok", int'(readin_ok), 1);

        // set=0 pause in layer-0 STEADY
        do_load("pause");
        start(1'b0);
        repeat (4) tick();
        chk("pause pre bf_idx", int'(bf_idx), 4);
        set = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("pause %0d bf_idx", i), int'(bf_idx), 4);
            chk($sformatf("pause %0d rd_en", i), int'(rd_en), 1);
            chk($sformatf("pause %0d wr_en", i), int'(wr_en), 1);
        end
        set = 1'b1;
        tick();
        chk("resume bf_idx", int'(bf_idx), 5);
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("pause enabled cycles to done", n + 4, 36);
        chk("pause done", int'(done), 1);
`ifdef NTT_LAYER_CTRL_PERF_EN
        chk("pause cycle_cnt", int'(cycle_cnt), 36);
`endif
        unload("pause");

        // Async reset pulse during DRAIN of layer 0
        do_load("rst");
        start(1'b0);
        repeat (9) tick();
        chk("rst pre wr_en", int'(wr_en), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst ram2_we", int'(ram2_we), 0);
        chk("rst readin_ok", int'(readin_ok), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst bf_idx", int'(bf_idx), 0);
        #1 reset_n = 1'b1;
        tick();
        chk("rst after busy", int'(busy), 0);
        chk("rst after rd_en", int'(rd_en), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
